// File: rtl/posit_add_arbiter.sv
// Round-robin arbiter sharing one combinational posit adder among NREQ requesters,
// with a tagged valid/ready response port and a done-timeout watchdog.
module posit_add_arbiter #(
    parameter int N       = 16,
    parameter int es      = 2,
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_in1,
    input  logic [NREQ*N-1:0] req_in2,
    output logic [N-1:0]      add_in1,
    output logic [N-1:0]      add_in2,
    output logic              add_start,
    input  logic [N-1:0]      add_out,
    input  logic              add_inf,
    input  logic              add_zero,
    input  logic              add_done,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [N-1:0]      rsp_out,
    output logic              rsp_inf,
    output logic              rsp_zero,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    // Handshake rule: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never depends on ready, and rsp_* stay frozen while rsp_valid=1 and rsp_ready=0.

    if (es < 0 || NREQ < 2 || NREQ > 16 || TIMEOUT < 1 || TIMEOUT > 255 || (1 << IDW) < NREQ)
    begin : g_param_check
        $error("posit_add_arbiter: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam logic [7:0]   TCNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [N-1:0] NAR       = {1'b1, {(N-1){1'b0}}};

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_gid;
    logic [N-1:0]   r_op1;
    logic [N-1:0]   r_op2;
    logic           r_add_start;
    logic [7:0]     r_tcnt;
    logic           r_rsp_valid;
    logic [N-1:0]   r_rsp_out;
    logic           r_rsp_inf;
    logic           r_rsp_zero;
    logic           r_rsp_err;

    logic           w_found;
    logic [IDW-1:0] w_grant;
    logic [N-1:0]   w_sel1;
    logic [N-1:0]   w_sel2;

    // First valid requester at or after r_ptr, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!w_found && req_valid[(int'(r_ptr) + k) % NREQ]) begin
                w_found = 1'b1;
                w_grant = IDW'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    assign w_sel1 = req_in1[int'(w_grant) * N +: N];
    assign w_sel2 = req_in2[int'(w_grant) * N +: N];

    // Gated by rst so no requester sees an accept while the block is held in reset.
    assign req_ready = (r_state == S_IDLE && w_found && !rst) ? (NREQ'(1) << w_grant) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_gid       <= '0;
            r_op1       <= '0;
            r_op2       <= '0;
            r_add_start <= 1'b0;
            r_tcnt      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_out   <= '0;
            r_rsp_inf   <= 1'b0;
            r_rsp_zero  <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_add_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_op1       <= w_sel1;
                        r_op2       <= w_sel2;
                        r_gid       <= w_grant;
                        r_add_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (add_done) begin
                        r_rsp_out   <= add_out;
                        r_rsp_inf   <= add_inf;
                        r_rsp_zero  <= add_zero;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tcnt  <= '0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (add_done) begin
                        r_rsp_out   <= add_out;
                        r_rsp_inf   <= add_inf;
                        r_rsp_zero  <= add_zero;
                        r_rsp_err   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else if (r_tcnt == TCNT_LAST) begin
                        // Adder never answered: report NaR flagged as a watchdog error.
                        r_rsp_out   <= NAR;
                        r_rsp_inf   <= 1'b1;
                        r_rsp_zero  <= 1'b0;
                        r_rsp_err   <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 8'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_ptr       <= (r_gid == IDW'(NREQ - 1)) ? '0 : r_gid + 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign add_in1   = r_op1;
    assign add_in2   = r_op2;
    assign add_start = r_add_start;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_gid;
    assign rsp_out   = r_rsp_out;
    assign rsp_inf   = r_rsp_inf;
    assign rsp_zero  = r_rsp_zero;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

endmodule
